// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : Multi-cycle multiply/divide sequencer for the E stage. Latches
//            operands on start, models the MDU latency with a down-counter,
//            and owns the HI/LO registers (mult/multu/div/divu/mthi/mtlo).
// Ports    : clk      - system clock, all state updates on rising edge
//            reset    - synchronous active-high reset
//            start    - 1-cycle pulse: E-stage instr is mult/multu/div/divu
//            mdu_op   - 000 mult 001 multu 010 div 011 divu 100 mthi
//                       101 mtlo 110 madd 111 maddu
//            we_hilo  - E-stage instr is mthi/mtlo (selected by mdu_op)
//            A, B     - rs / rt operands (forwarded)
//            busy     - operation in progress (registered)
//            hi, lo   - HI / LO registers
// Options  : `define MDU_MADD_EN enables madd/maddu (110/111), which
//            accumulate the 64-bit product into {hi,lo}. Without it a start
//            with mdu_op 110/111 is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic        we_hilo,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] c_OP_MULT  = 3'b000;
  localparam logic [2:0] c_OP_MULTU = 3'b001;
  localparam logic [2:0] c_OP_DIV   = 3'b010;
  localparam logic [2:0] c_OP_DIVU  = 3'b011;
  localparam logic [2:0] c_OP_MTHI  = 3'b100;
  localparam logic [2:0] c_OP_MTLO  = 3'b101;
  localparam logic [2:0] c_OP_MADD  = 3'b110;
  localparam logic [2:0] c_OP_MADDU = 3'b111;

  localparam int unsigned c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W     = $clog2(c_MAX_CYC + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  // --------------------------------------------------------------------------
  // Start decode: only real MDU operations launch the sequencer.
  // --------------------------------------------------------------------------
  logic w_start_mul;
  logic w_start_div;
  logic w_accept;

  always_comb begin
    w_start_mul = (mdu_op == c_OP_MULT) || (mdu_op == c_OP_MULTU);
    w_start_div = (mdu_op == c_OP_DIV)  || (mdu_op == c_OP_DIVU);
`ifdef MDU_MADD_EN
    w_start_mul = w_start_mul || (mdu_op == c_OP_MADD) || (mdu_op == c_OP_MADDU);
`endif
    w_accept    = start && (w_start_mul || w_start_div);
  end

  // --------------------------------------------------------------------------
  // Datapath on the latched operands.
  // The signed product is the low 64 bits of the product of the sign-extended
  // operands, so one 64-bit multiplier form serves both signednesses.
  // --------------------------------------------------------------------------
  logic [63:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx;
  logic [63:0] w_prod_s, w_prod_u;

  always_comb begin
    w_a_sx   = {{32{a_q[31]}}, a_q};
    w_b_sx   = {{32{b_q[31]}}, b_q};
    w_a_zx   = {32'h0, a_q};
    w_b_zx   = {32'h0, b_q};
    w_prod_s = w_a_sx * w_b_sx;
    w_prod_u = w_a_zx * w_b_zx;
  end

  // Division runs on magnitudes; signs are reapplied afterwards. This keeps
  // 0x80000000 / -1 well defined: the magnitude quotient 0x80000000 negates
  // back to itself with a zero remainder.
  logic        w_div_signed;
  logic        w_dvd_neg, w_dvs_neg;
  logic [31:0] w_dvd_mag, w_dvs_mag;
  logic [31:0] w_quo_mag, w_rem_mag;
  logic [31:0] w_quo, w_rem;

  always_comb begin
    w_div_signed = (op_q == c_OP_DIV);
    w_dvd_neg    = w_div_signed && a_q[31];
    w_dvs_neg    = w_div_signed && b_q[31];
    w_dvd_mag    = w_dvd_neg ? (~a_q + 32'd1) : a_q;
    w_dvs_mag    = w_dvs_neg ? (~b_q + 32'd1) : b_q;
    w_quo_mag    = w_dvd_mag / w_dvs_mag;
    w_rem_mag    = w_dvd_mag % w_dvs_mag;
    w_quo        = (w_dvd_neg ^ w_dvs_neg) ? (~w_quo_mag + 32'd1) : w_quo_mag;
    w_rem        = w_dvd_neg ? (~w_rem_mag + 32'd1) : w_rem_mag;
  end

  // Result selection; divide by zero leaves hi/lo untouched.
  logic        w_wr_en;
  logic [63:0] w_result;

  always_comb begin
    w_wr_en  = 1'b0;
    w_result = {hi_q, lo_q};
    case (op_q)
      c_OP_MULT:  begin w_wr_en = 1'b1; w_result = w_prod_s; end
      c_OP_MULTU: begin w_wr_en = 1'b1; w_result = w_prod_u; end
      c_OP_DIV,
      c_OP_DIVU:  begin w_wr_en = (b_q != 32'h0); w_result = {w_rem, w_quo}; end
`ifdef MDU_MADD_EN
      c_OP_MADD:  begin w_wr_en = 1'b1; w_result = {hi_q, lo_q} + w_prod_s; end
      c_OP_MADDU: begin w_wr_en = 1'b1; w_result = {hi_q, lo_q} + w_prod_u; end
`endif
      default:    begin w_wr_en = 1'b0; w_result = {hi_q, lo_q}; end
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // start has priority over a simultaneous we_hilo
          if (w_accept) begin
            a_d     = A;
            b_d     = B;
            op_d    = mdu_op;
            cnt_d   = w_start_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d = S_RUN;
          end
        end else if (we_hilo) begin
          if (mdu_op == c_OP_MTHI) begin
            hi_d = A;
          end else if (mdu_op == c_OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      S_RUN: begin
        // start/we_hilo are deliberately ignored here; no queueing
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (w_wr_en) begin
            {hi_d, lo_d} = w_result;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that sits in the E stage beside the single-cycle ALU.
- Latches operands on start, models the mult/div latency with a down-counter, and owns the HI/LO registers.
- Exposes busy so the hazard unit stalls later MDU instructions in D.
- Serves mult/multu/div/divu/mthi/mtlo; mfhi/mflo read the hi/lo outputs directly.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (≥1)
DIV_CYCLES, 10, busy duration in cycles for div/divu (≥1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: E-stage instruction is mult/multu/div/divu
mdu_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 maddu
we_hilo  input  1  E-stage instruction is mthi/mtlo (selected by mdu_op)
A  input  32  rs operand (forwarded)
B  input  32  rt operand (forwarded)
busy  output  1  operation in progress
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset:
  - Takes effect in any state, including mid-operation; the pending result is discarded.
  - After reset: state IDLE, busy=0, hi=0, lo=0, counter=0.
- FSM states:
  - IDLE: if start=1, latch A, B and mdu_op; load counter with MULT_CYCLES (ops 000/001/110/111) or DIV_CYCLES (010/011); go to RUN.
  - RUN: decrement counter each cycle. On the edge where the counter reaches 0, write hi/lo with the result and return to IDLE.
- busy:
  - busy = (state==RUN), registered.
  - Rises the cycle after start and stays high exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - New hi/lo values are visible in the first cycle that busy=0.
- Hazard contract:
  - The hazard unit stalls any MDU instruction in D while (start | busy).
  - The block itself ignores start and we_hilo while busy=1; no queueing.
- mthi/mtlo:
  - In IDLE with we_hilo=1 and start=0, write A to hi (100) or lo (101) at the next edge; busy is not affected.
  - start=1 together with we_hilo=1 is illegal; start wins.
- Arithmetic, on the latched operands:
  - mult: {hi,lo} = $signed(A) * $signed(B), 64-bit.
  - multu: unsigned 64-bit product.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - div corner case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient/remainder.
- Divide by zero (B==0): still takes DIV_CYCLES with busy asserted; hi/lo are left unchanged.
- Operands are latched at start, so changes on A/B during RUN have no effect.
- mdu_op 110/111 behave as described under Optional Feature.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - madd (110): {hi,lo} += signed 64-bit A*B.
  - maddu (111): {hi,lo} += unsigned 64-bit A*B.
  - Both take MULT_CYCLES; the sum wraps modulo 2^64.
- Undefined: start with mdu_op 110/111 is ignored; state stays IDLE, busy stays 0, hi/lo unchanged.

Test Plan:
1. Reset mid-op: mult, then reset=1 on the 2nd busy cycle → next cycle busy=0, hi=0, lo=0; no later write of hi/lo.
2. mult A=0xFFFFFFFF, B=0x00000002, start 1 cycle → busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with multu → hi=0x00000001, lo=0xFFFFFFFE.
3. div A=0xFFFFFFF9 (-7), B=2 → busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=0 → busy for 10 cycles; hi/lo keep their prior values.
4. mthi A=0x12345678, then mtlo A=0x9ABCDEF0 in consecutive cycles → hi/lo updated one edge after each. mtlo and a second start issued while busy → both ignored; result equals the first operation's result.
5. MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, madd A=1, B=1 → hi=1, lo=0 after 5 cycles. Macro undefined, same stimulus → busy stays 0, hi/lo unchanged.
